// File: rtl/mem_dbus_ctrl_pkg.sv
// Shared constants for the MEM-stage data-bus controller: access-type bits, size codes,
// exception code width and the controller state encoding.
package mem_dbus_ctrl_pkg;

    localparam int              EXC_CODE_W = 5;
    localparam logic [4:0]      EXC_NONE   = 5'h10;
    localparam logic [31:0]     ZERO_WORD  = 32'h0000_0000;

    localparam int MT_LB  = 0;
    localparam int MT_LBU = 1;
    localparam int MT_LH  = 2;
    localparam int MT_LHU = 3;
    localparam int MT_LW  = 4;
    localparam int MT_SB  = 5;
    localparam int MT_SH  = 6;
    localparam int MT_SW  = 7;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ1,
        S_WAIT1,
        S_REQ2,
        S_WAIT2,
        S_DONE,
        S_DRAIN
    } state_t;

    function automatic logic [1:0] access_size(input logic [7:0] mt);
        if (mt[MT_LW] || mt[MT_SW])
            return SIZE_WORD;
        else if (mt[MT_LH] || mt[MT_LHU] || mt[MT_SH])
            return SIZE_HALF;
        else if (mt[MT_LB] || mt[MT_LBU] || mt[MT_SB])
            return SIZE_BYTE;
        else
            return SIZE_BYTE;
    endfunction

    // Narrow stores replicate their data across every lane so the slave can pick any lane.
    function automatic logic [31:0] store_wdata(input logic [1:0] size, input logic [31:0] data);
        case (size)
            SIZE_BYTE: return {4{data[7:0]}};
            SIZE_HALF: return {2{data[15:0]}};
            default:   return data;
        endcase
    endfunction

endpackage

// File: rtl/mem_dbus_ctrl_load_ext.sv
// Little-endian lane select plus sign/zero extension of a raw bus read word.
module mem_dbus_ctrl_load_ext
    import mem_dbus_ctrl_pkg::*;
(
    input  logic [4:0]  load_type,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] rdata,
    output logic [31:0] ldata
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        case (addr_lo)
            2'd0:    lane_b = rdata[7:0];
            2'd1:    lane_b = rdata[15:8];
            2'd2:    lane_b = rdata[23:16];
            default: lane_b = rdata[31:24];
        endcase
        lane_h = addr_lo[1] ? rdata[31:16] : rdata[15:0];

        ldata = ZERO_WORD;
        if (load_type[MT_LB])
            ldata = {{24{lane_b[7]}}, lane_b};
        else if (load_type[MT_LBU])
            ldata = {24'h0, lane_b};
        else if (load_type[MT_LH])
            ldata = {{16{lane_h[15]}}, lane_h};
        else if (load_type[MT_LHU])
            ldata = {16'h0, lane_h};
        else if (load_type[MT_LW])
            ldata = rdata;
    end

endmodule

// File: rtl/mem_dbus_ctrl.sv
// MEM-stage data-bus controller: serialises the two slots of a dual-issue pair onto a
// single-outstanding request/address-ok/data-ok bus and stalls the pipeline meanwhile.
module mem_dbus_ctrl
    import mem_dbus_ctrl_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  wb_ready,
    input  logic [7:0]            mem_inst1_memtype,
    input  logic [7:0]            mem_inst2_memtype,
    input  logic [31:0]           mem_inst1_w2regdata,
    input  logic [31:0]           mem_inst2_w2regdata,
    input  logic [31:0]           mem_inst1_w2ramdata,
    input  logic [31:0]           mem_inst2_w2ramdata,
    input  logic [EXC_CODE_W-1:0] mem_exe_exccode,
    output logic                  data_req,
    output logic                  data_wr,
    output logic [1:0]            data_size,
    output logic [31:0]           data_addr,
    output logic [31:0]           data_wdata,
    input  logic                  data_addr_ok,
    input  logic                  data_data_ok,
    input  logic [31:0]           data_rdata,
    output logic [31:0]           inst1_ldata,
    output logic [31:0]           inst2_ldata,
    output logic                  stallreq_mem
);

    state_t      state;
    logic        op1, op2;
    logic [1:0]  size1, size2;
    logic [31:0] wdata1, wdata2;
    logic [4:0]  ext_type;
    logic [1:0]  ext_addr_lo;
    logic [31:0] ext_data;

    assign op1 = (mem_inst1_memtype != 8'd0) && (mem_exe_exccode == EXC_NONE) && !flush;
    assign op2 = (mem_inst2_memtype != 8'd0) && (mem_exe_exccode == EXC_NONE) && !flush;

    assign size1  = access_size(mem_inst1_memtype);
    assign size2  = access_size(mem_inst2_memtype);
    assign wdata1 = store_wdata(size1, mem_inst1_w2ramdata);
    assign wdata2 = store_wdata(size2, mem_inst2_w2ramdata);

    assign stallreq_mem = !rst && (op1 || op2) && (state != S_DONE) && (state != S_DRAIN);

    assign ext_type    = (state == S_WAIT2) ? mem_inst2_memtype[4:0] : mem_inst1_memtype[4:0];
    assign ext_addr_lo = (state == S_WAIT2) ? mem_inst2_w2regdata[1:0] : mem_inst1_w2regdata[1:0];

    mem_dbus_ctrl_load_ext u_load_ext (
        .load_type (ext_type),
        .addr_lo   (ext_addr_lo),
        .rdata     (data_rdata),
        .ldata     (ext_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            data_req    <= 1'b0;
            data_wr     <= 1'b0;
            data_size   <= SIZE_BYTE;
            data_addr   <= ZERO_WORD;
            data_wdata  <= ZERO_WORD;
            inst1_ldata <= ZERO_WORD;
            inst2_ldata <= ZERO_WORD;
        end else begin
            case (state)
                S_IDLE: begin
                    if (op1) begin
                        data_req   <= 1'b1;
                        data_wr    <= |mem_inst1_memtype[7:5];
                        data_size  <= size1;
                        data_addr  <= mem_inst1_w2regdata;
                        data_wdata <= wdata1;
                        state      <= S_REQ1;
                    end else if (op2) begin
                        data_req   <= 1'b1;
                        data_wr    <= |mem_inst2_memtype[7:5];
                        data_size  <= size2;
                        data_addr  <= mem_inst2_w2regdata;
                        data_wdata <= wdata2;
                        state      <= S_REQ2;
                    end
                end
                S_REQ1, S_REQ2: begin
                    // A flush racing an accepted address still owes us a data_ok, so drain it.
                    if (flush) begin
                        data_req <= 1'b0;
                        data_wr  <= 1'b0;
                        state    <= data_addr_ok ? S_DRAIN : S_IDLE;
                    end else if (data_addr_ok) begin
                        data_req <= 1'b0;
                        data_wr  <= 1'b0;
                        state    <= (state == S_REQ1) ? S_WAIT1 : S_WAIT2;
                    end
                end
                S_WAIT1: begin
                    if (data_data_ok) begin
                        if (flush) begin
                            state <= S_IDLE;
                        end else begin
                            if (|mem_inst1_memtype[4:0])
                                inst1_ldata <= ext_data;
                            if (op2) begin
                                data_req   <= 1'b1;
                                data_wr    <= |mem_inst2_memtype[7:5];
                                data_size  <= size2;
                                data_addr  <= mem_inst2_w2regdata;
                                data_wdata <= wdata2;
                                state      <= S_REQ2;
                            end else begin
                                state <= S_DONE;
                            end
                        end
                    end else if (flush) begin
                        state <= S_DRAIN;
                    end
                end
                S_WAIT2: begin
                    if (data_data_ok) begin
                        if (flush) begin
                            state <= S_IDLE;
                        end else begin
                            if (|mem_inst2_memtype[4:0])
                                inst2_ldata <= ext_data;
                            state <= S_DONE;
                        end
                    end else if (flush) begin
                        state <= S_DRAIN;
                    end
                end
                S_DONE: begin
                    if (flush || wb_ready)
                        state <= S_IDLE;
                end
                S_DRAIN: begin
                    if (data_data_ok)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_dbus_ctrl.sv
// Directed bench for mem_dbus_ctrl: inputs change just after negedge, outputs are checked 1ns later.
module tb_mem_dbus_ctrl;
    import mem_dbus_ctrl_pkg::*;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  flush;
    logic                  wb_ready;
    logic [7:0]            mt1, mt2;
    logic [31:0]           addr1, addr2;
    logic [31:0]           wd1, wd2;
    logic [EXC_CODE_W-1:0] exccode;
    logic                  data_req, data_wr;
    logic [1:0]            data_size;
    logic [31:0]           data_addr, data_wdata;
    logic                  addr_ok, data_ok;
    logic [31:0]           rdata;
    logic [31:0]           ldata1, ldata2;
    logic                  stall;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_dbus_ctrl dut (
        .clk                 (clk),
        .rst                 (rst),
        .flush               (flush),
        .wb_ready            (wb_ready),
        .mem_inst1_memtype   (mt1),
        .mem_inst2_memtype   (mt2),
        .mem_inst1_w2regdata (addr1),
        .mem_inst2_w2regdata (addr2),
        .mem_inst1_w2ramdata (wd1),
        .mem_inst2_w2ramdata (wd2),
        .mem_exe_exccode     (exccode),
        .data_req            (data_req),
        .data_wr             (data_wr),
        .data_size           (data_size),
        .data_addr           (data_addr),
        .data_wdata          (data_wdata),
        .data_addr_ok        (addr_ok),
        .data_data_ok        (data_ok),
        .data_rdata          (rdata),
        .inst1_ldata         (ldata1),
        .inst2_ldata         (ldata2),
        .stallreq_mem        (stall)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(negedge clk);
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; wb_ready = 1'b0;
        mt1 = 8'h00; mt2 = 8'h00; addr1 = 32'h0; addr2 = 32'h0; wd1 = 32'h0; wd2 = 32'h0;
        exccode = EXC_NONE; addr_ok = 1'b0; data_ok = 1'b0; rdata = 32'h0;

        // Reset state
        next_cycle(); next_cycle(); settle();
        check("rst_req",    32'(data_req),   32'h0);
        check("rst_wr",     32'(data_wr),    32'h0);
        check("rst_size",   32'(data_size),  32'h0);
        check("rst_addr",   data_addr,       32'h0);
        check("rst_wdata",  data_wdata,      32'h0);
        check("rst_ld1",    ldata1,          32'h0);
        check("rst_ld2",    ldata2,          32'h0);
        check("rst_stall",  32'(stall),      32'h0);
        rst = 1'b0;

        // LW 0x1004, addr_ok at once, data_ok next cycle
        next_cycle(); mt1 = 8'h10; addr1 = 32'h0000_1004; settle();
        check("lw_idle_stall", 32'(stall),    32'h1);
        check("lw_idle_req",   32'(data_req), 32'h0);
        next_cycle(); addr_ok = 1'b1; settle();
        check("lw_req",        32'(data_req),  32'h1);
        check("lw_addr",       data_addr,      32'h0000_1004);
        check("lw_wr",         32'(data_wr),   32'h0);
        check("lw_size",       32'(data_size), 32'h2);
        check("lw_req_stall",  32'(stall),     32'h1);
        next_cycle(); addr_ok = 1'b0; data_ok = 1'b1; rdata = 32'hDEAD_BEEF; settle();
        check("lw_wait_req",   32'(data_req), 32'h0);
        check("lw_wait_stall", 32'(stall),    32'h1);
        next_cycle(); data_ok = 1'b0; rdata = 32'h0; wb_ready = 1'b1; settle();
        check("lw_done_stall", 32'(stall), 32'h0);
        check("lw_ldata",      ldata1,     32'hDEAD_BEEF);
        next_cycle(); wb_ready = 1'b0; mt1 = 8'h00; settle();
        check("lw_idle_after", 32'(data_req), 32'h0);

        // SB then LBU to the same byte, issued in slot order
        next_cycle(); mt1 = 8'h20; addr1 = 32'h2003; wd1 = 32'h5A;
        mt2 = 8'h02; addr2 = 32'h2003; settle();
        check("sb_idle_stall", 32'(stall), 32'h1);
        next_cycle(); addr_ok = 1'b1; settle();
        check("sb_req",    32'(data_req),  32'h1);
        check("sb_wr",     32'(data_wr),   32'h1);
        check("sb_size",   32'(data_size), 32'h0);
        check("sb_addr",   data_addr,      32'h2003);
        check("sb_wdata",  data_wdata,     32'h5A5A_5A5A);
        next_cycle(); addr_ok = 1'b0; data_ok = 1'b1; rdata = 32'h1111_1111; settle();
        check("sb_wait_req",   32'(data_req), 32'h0);
        check("sb_wait_stall", 32'(stall),    32'h1);
        next_cycle(); data_ok = 1'b0; addr_ok = 1'b1; rdata = 32'h0; settle();
        check("lbu_req",   32'(data_req),  32'h1);
        check("lbu_wr",    32'(data_wr),   32'h0);
        check("lbu_size",  32'(data_size), 32'h0);
        check("lbu_addr",  data_addr,      32'h2003);
        check("sb_keeps_ld1", ldata1,      32'hDEAD_BEEF);
        next_cycle(); addr_ok = 1'b0; data_ok = 1'b1; rdata = 32'h5A00_0000; settle();
        check("lbu_wait_stall", 32'(stall), 32'h1);
        next_cycle(); data_ok = 1'b0; rdata = 32'h0; wb_ready = 1'b1; settle();
        check("lbu_ldata2",     ldata2,      32'h0000_005A);
        check("lbu_done_stall", 32'(stall),  32'h0);
        check("lbu_keeps_ld1",  ldata1,      32'hDEAD_BEEF);
        next_cycle(); wb_ready = 1'b0; mt1 = 8'h00; mt2 = 8'h00; settle();

        // LH upper half, sign-extended
        next_cycle(); mt1 = 8'h04; addr1 = 32'h3002; settle();
        next_cycle(); addr_ok = 1'b1; settle();
        check("lh_size", 32'(data_size), 32'h1);
        next_cycle(); addr_ok = 1'b0; data_ok = 1'b1; rdata = 32'h8001_0000; settle();
        next_cycle(); data_ok = 1'b0; rdata = 32'h0; wb_ready = 1'b1; settle();
        check("lh_ldata", ldata1, 32'hFFFF_8001);
        next_cycle(); wb_ready = 1'b0; mt1 = 8'h00; settle();

        // Flush in WAIT1, data_ok arrives 4 cycles later, new op waits until drain ends
        next_cycle(); mt1 = 8'h10; addr1 = 32'h4000; settle();
        next_cycle(); addr_ok = 1'b1; settle();
        next_cycle(); addr_ok = 1'b0; flush = 1'b1; settle();
        check("fl_wait_stall", 32'(stall), 32'h0);
        next_cycle(); flush = 1'b0; mt1 = 8'h00; settle();
        check("drain_req_a",   32'(data_req), 32'h0);
        check("drain_stall_a", 32'(stall),    32'h0);
        next_cycle(); settle();
        check("drain_req_b",   32'(data_req), 32'h0);
        next_cycle(); mt1 = 8'h10; addr1 = 32'h5000; settle();
        check("drain_stall_op", 32'(stall),   32'h0);
        check("drain_req_c",    32'(data_req), 32'h0);
        next_cycle(); data_ok = 1'b1; rdata = 32'h1234_5678; settle();
        check("drain_req_d",   32'(data_req), 32'h0);
        check("drain_stall_d", 32'(stall),    32'h0);
        next_cycle(); data_ok = 1'b0; rdata = 32'h0; settle();
        check("drain_ld1_kept", ldata1,        32'hFFFF_8001);
        check("post_drain_stall", 32'(stall),  32'h1);
        check("post_drain_req",   32'(data_req), 32'h0);
        next_cycle(); addr_ok = 1'b1; settle();
        check("post_drain_issue", 32'(data_req), 32'h1);
        check("post_drain_addr",  data_addr,     32'h5000);
        next_cycle(); addr_ok = 1'b0; data_ok = 1'b1; rdata = 32'hCAFE_F00D; settle();
        next_cycle(); data_ok = 1'b0; rdata = 32'h0; wb_ready = 1'b1; settle();
        check("post_drain_ld1", ldata1, 32'hCAFE_F00D);
        next_cycle(); wb_ready = 1'b0; mt1 = 8'h00; settle();

        // Pending exception suppresses the access
        next_cycle(); mt1 = 8'h10; addr1 = 32'h4444; exccode = 5'h04; settle();
        check("exc_stall", 32'(stall),    32'h0);
        next_cycle(); settle();
        check("exc_req",   32'(data_req), 32'h0);
        next_cycle(); mt1 = 8'h00; exccode = EXC_NONE; settle();

        // Flush in REQ2 drops the request
        next_cycle(); mt2 = 8'h08; addr2 = 32'h7002; settle();
        check("req2_stall", 32'(stall), 32'h1);
        next_cycle(); flush = 1'b1; settle();
        check("req2_req",       32'(data_req), 32'h1);
        check("req2_fl_stall",  32'(stall),    32'h0);
        next_cycle(); flush = 1'b0; mt2 = 8'h00; settle();
        check("req2_dropped",   32'(data_req), 32'h0);

        // Reset in WAIT2
        next_cycle(); mt1 = 8'h10; addr1 = 32'h6000; mt2 = 8'h10; addr2 = 32'h6004; settle();
        next_cycle(); addr_ok = 1'b1; settle();
        next_cycle(); addr_ok = 1'b0; data_ok = 1'b1; rdata = 32'h0102_0304; settle();
        next_cycle(); data_ok = 1'b0; addr_ok = 1'b1; rdata = 32'h0; settle();
        check("w2_addr", data_addr, 32'h6004);
        next_cycle(); addr_ok = 1'b0; rst = 1'b1; mt1 = 8'h00; mt2 = 8'h00; settle();
        next_cycle(); rst = 1'b0; settle();
        check("w2rst_req",   32'(data_req),  32'h0);
        check("w2rst_wr",    32'(data_wr),   32'h0);
        check("w2rst_size",  32'(data_size), 32'h0);
        check("w2rst_addr",  data_addr,      32'h0);
        check("w2rst_wdata", data_wdata,     32'h0);
        check("w2rst_ld1",   ldata1,         32'h0);
        check("w2rst_ld2",   ldata2,         32'h0);
        check("w2rst_stall", 32'(stall),     32'h0);

        next_cycle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_dbus_ctrl.md
MEM_DBUS_CTRL -- requirements
Module: mem_dbus_ctrl

Interface
REQ-001 clk  in  1  pipeline clock; all state changes on posedge clk.
REQ-002 rst  in  1  reset; synchronous, active-high.
REQ-003 flush  in  1  squash the current MEM-stage pair (exception/eret).
REQ-004 wb_ready  in  1  MEM/WB register accepts this cycle (its stall bit = NOSTOP).
REQ-005 mem_inst1_memtype / mem_inst2_memtype  in  8 each  one-hot access type: [0]LB [1]LBU [2]LH [3]LHU [4]LW [5]SB [6]SH [7]SW; 0 = no access.
REQ-006 mem_inst1_w2regdata / mem_inst2_w2regdata  in  32 each  effective address, already aligned.
REQ-007 mem_inst1_w2ramdata / mem_inst2_w2ramdata  in  32 each  store data, right-justified.
REQ-008 mem_exe_exccode  in  EXC_CODE_BUS  pending exception of the pair; != EXC_NONE suppresses both accesses.
REQ-009 data_req / data_wr  out  1 each  bus request / write flag.
REQ-010 data_size  out  2  0 = byte, 1 = half, 2 = word.
REQ-011 data_addr / data_wdata  out  32 each  bus address / write data.
REQ-012 data_addr_ok / data_data_ok  in  1 each  address accepted / data returned or write done.
REQ-013 data_rdata  in  32  raw read word.
REQ-014 inst1_ldata / inst2_ldata  out  32 each  extended load result, registered.
REQ-015 stallreq_mem  out  1  pipeline stall request to the hazard unit.

Function
REQ-016 FSM states: IDLE, REQ1, WAIT1, REQ2, WAIT2, DONE, DRAIN.
REQ-017 Per slot, "opN" = memtype != 0, exccode == EXC_NONE, and flush == 0.
REQ-018 IDLE: op1 -> REQ1; else op2 -> REQ2; else stay.
REQ-019 REQx drives data_req=1 with slot x fields and holds them until data_addr_ok; addr_ok -> WAITx.
REQ-020 WAIT1 + data_ok: capture inst1_ldata; op2 -> REQ2, else -> DONE. WAIT2 + data_ok: capture inst2_ldata -> DONE.
REQ-021 DONE: stallreq_mem=0; wb_ready -> IDLE, else hold DONE so no access repeats.
REQ-022 stallreq_mem = (op1|op2) && state != DONE, combinational; high in IDLE the cycle an op appears.
REQ-023 Minimum latency, one load, addr_ok and data_ok each on the first eligible cycle: 3 stalled cycles, then DONE.
REQ-024 data_wr=1 for SB/SH/SW; data_size from type; data_wdata = byte replicated x4, half x2, or word.
REQ-025 Loads are little-endian: byte lane addr[1:0], half lane addr[1]; LB/LH sign-extend, LBU/LHU zero-extend.
REQ-026 Stores leave ldata unchanged; ldata holds until the next load in that slot.
REQ-027 flush in REQx drops the request (data_req=0 next cycle) -> IDLE.
REQ-028 flush in WAITx -> DRAIN; DRAIN waits for data_ok, discards rdata, then -> IDLE; stallreq_mem=0 in DRAIN.
REQ-029 A new access is never issued from DRAIN; at most one transaction is outstanding.
REQ-030 data_ok in a REQ state is a bus-protocol violation and is ignored.
REQ-031 flush in DONE or IDLE -> IDLE.

Reset
REQ-032 rst -> state IDLE, data_req=0, data_wr=0, data_size=0, data_addr=0, data_wdata=0, ldata=0, stallreq_mem=0.
REQ-033 rst mid-transaction abandons it without draining; the bus slave is reset by the same rst.

Structure
REQ-034 Memtype bit positions, state encoding, and size codes belong in defines.v beside EXC_NONE and ZERO_WORD.
REQ-035 One sub-module, load_ext, is natural: combinational extension (memtype, addr[1:0], rdata) -> 32-bit result; it is instantiated once.

Verification
REQ-036 LW 0x0000_1004, addr_ok at once, data_ok next cycle, rdata 0xDEADBEEF -> inst1_ldata=0xDEADBEEF, stallreq high 3 cycles.
REQ-037 Slot 1 SB 0x2003 data 0x5A and slot 2 LBU 0x2003 with rdata 0x5A000000 -> write wdata 0x5A5A5A5A, size 0; then read; inst2_ldata=0x0000005A, in order.
REQ-038 LH 0x3002 with rdata 0x8001_0000 -> inst1_ldata=0xFFFF8001.
REQ-039 flush in WAIT1 with data_ok 4 cycles later -> DRAIN, no ldata update, no second request.
REQ-040 exccode != EXC_NONE with LW in slot 1 -> no data_req, stallreq_mem=0.
REQ-041 rst in WAIT2 -> next cycle IDLE, all outputs 0.
